mbc_gen: RTL and testbench
==========================

Name: mbc_gen

Overview:
Parametrised cartridge memory bank controller, successor to the fixed 5-bit MBC1 controller.
- Sits on the Game Boy CPU bus: address, indata, outdata, load, store.
- Drives external ROM and external banked cart RAM, both synchronous with 1-cycle read latency.
- Supports MBC1 mode (banking-mode select, upper bank bits, RAM enable) and MBC5 mode (9-bit ROM bank, 16 RAM banks).
- Adds a battery-save dump engine that streams all cart RAM out over a valid/ready byte port.

Parameters:
MODE, 0, 0 = MBC1 register map, 1 = MBC5 register map
ROM_BANK_BITS, 7, ROM bank register width; legal 1..7 for MBC1, 1..9 for MBC5
RAM_BANK_BITS, 2, RAM bank select width; legal 0..2 for MBC1, 0..4 for MBC5

Ports:
clockgb  in  1  system clock, all state on rising edge
resetn  in  1  reset, asynchronous, active-low
address  in  16  CPU address
indata  in  8  CPU write data
outdata  out  8  CPU read data; 0x00 when not driving (OR-combined bus)
load  in  1  CPU read strobe
store  in  1  CPU write strobe
rom_addr  out  ROM_BANK_BITS+14  external ROM byte address
rom_data  in  8  ROM read data, valid the cycle after rom_addr
ram_addr  out  RAM_BANK_BITS+13  cart RAM byte address
ram_wdata  out  8  cart RAM write data
ram_we  out  1  cart RAM write enable, 1 cycle
ram_rdata  in  8  cart RAM read data, valid the cycle after ram_addr
dump_start  in  1  1-cycle pulse: begin RAM dump
dump_valid  out  1  dump_data valid
dump_ready  in  1  consumer accepts byte when valid && ready
dump_data  out  8  dumped byte, ascending address order
dump_busy  out  1  dump in progress
ram_dirty  out  1  cart RAM written since last dump start

Behaviour:
- Reset values:
  - rom_bank = 1; upper = 0; ram_en = 0; mode_sel = 0.
  - Dump FSM in IDLE.
  - outdata = 0x00; ram_we, dump_valid, dump_busy, ram_dirty = 0.
  - dump_data = 0x00; address counter = 0.
- Register writes (store, address 0x0000-0x7FFF, take effect next edge):
  - 0x0000-0x1FFF: ram_en = (indata[3:0] == 4'hA).
  - MBC1, 0x2000-0x3FFF: rom_bank[4:0] = indata[4:0]; a value of 0 becomes 1, so 0x20, 0x40 and 0x60 map to 0x21, 0x41 and 0x61.
  - MBC1, 0x4000-0x5FFF: upper = indata[1:0].
  - MBC1, 0x6000-0x7FFF: mode_sel = indata[0].
  - MBC5, 0x2000-0x2FFF: rom_bank[7:0] = indata; bank 0 allowed.
  - MBC5, 0x3000-0x3FFF: rom_bank[8] = indata[0].
  - MBC5, 0x4000-0x5FFF: upper = indata[3:0], used as RAM bank.
  - All bank values are truncated to ROM_BANK_BITS / RAM_BANK_BITS (wrap-around mirroring).
- Address mapping (combinational):
  - MBC1, 0x0000-0x3FFF: bank = mode_sel ? {upper, 5'b0} : 0.
  - MBC1, 0x4000-0x7FFF: bank = {upper, rom_bank[4:0]}.
  - MBC5: 0x0000-0x3FFF uses bank 0; 0x4000-0x7FFF uses rom_bank.
  - RAM bank: MBC1 uses mode_sel ? upper : 0; MBC5 uses upper.
- Reads:
  - load to 0x0000-0x7FFF or 0xA000-0xBFFF registers the region.
  - outdata carries the memory data in the following cycle only; 0x00 in all other cycles.
  - RAM read while ram_en = 0 or dump_busy returns 0xFF.
- RAM writes:
  - store to 0xA000-0xBFFF with ram_en = 1 and !dump_busy asserts ram_we for 1 cycle and sets ram_dirty.
  - Otherwise the write is dropped.
- Dump FSM states:
  - IDLE: on dump_start, set busy, clear ram_dirty and the counter, go to FETCH. dump_start while busy is ignored.
  - FETCH: drive ram_addr = counter, go to WAIT.
  - WAIT: latch ram_rdata into dump_data, set dump_valid, go to SEND.
  - SEND: hold data until dump_ready. Then drop valid; if the counter is at its last value (2^(RAM_BANK_BITS+13)-1), go to IDLE and clear busy; else increment the counter and go to FETCH.
- Dump port arbitration: while busy, ram_addr comes from the FSM. A CPU RAM load/store in the same cycle is handled per the dropped/0xFF rules.
- resetn asserted mid-dump aborts immediately to reset values; no partial completion signal.

Decomposition:
- Package mbc_pkg:
  - region constants: ROM0 0x0000-0x3FFF, ROMX 0x4000-0x7FFF, RAM 0xA000-0xBFFF, plus the register windows.
  - MODE_MBC1 and MODE_MBC5 values.
  - RAM enable key 4'hA.
  - Dump FSM state enum.
- Sub-module mbc_dump_fsm: dump counter, dump handshake and busy logic.

Test Plan:
- MBC1: write 0x00 to 0x2000, load 0x4000 -> rom_addr = 0x4000 (bank 1); write 0x20 to 0x2000, 0x01 to 0x4000 -> bank 0x21.
- MBC1: mode_sel = 1, upper = 2, load 0x0123 -> rom_addr = 0x100123; RAM access at 0xA005 -> ram_addr = 0x4005.
- MBC5, ROM_BANK_BITS = 9: write 0x00 to 0x2000, 0x01 to 0x3000, load 0x7FFF -> rom_addr = 0x403FFF; outdata = rom_data one cycle later, then 0x00.
- RAM gating: write to 0xA000 with ram_en = 0 -> no ram_we, ram_dirty stays 0, read returns 0xFF; write 0x0A to 0x0000, retry -> ram_we pulses, ram_dirty = 1.
- Dump, RAM_BANK_BITS = 0, with dump_ready toggling randomly:
  - exactly 8192 bytes accepted, in address order, matching the preloaded RAM;
  - ram_dirty cleared at start; dump_busy drops after the last byte;
  - a CPU write mid-dump is dropped.
- Reset mid-dump at byte 100 -> dump_busy = 0, dump_valid = 0, rom_bank = 1; a new dump_start restarts from address 0.

Source files
------------

// File: rtl/mbc_pkg.sv
// mbc_gen shared definitions: register windows, modes, dump states.
// Imported by the controller top and the dump engine.
package mbc_pkg;

  localparam int MODE_MBC1 = 0;
  localparam int MODE_MBC5 = 1;

  localparam logic [3:0] RAM_KEY = 4'hA;

  // address[15:14] regions
  localparam logic [1:0] RGN_ROM0 = 2'b00;
  localparam logic [1:0] RGN_ROMX = 2'b01;

  // address[15:13] windows
  localparam logic [2:0] WIN_RAMEN = 3'b000;
  localparam logic [2:0] WIN_ROMB  = 3'b001;
  localparam logic [2:0] WIN_UPPER = 3'b010;
  localparam logic [2:0] WIN_MODE  = 3'b011;
  localparam logic [2:0] WIN_RAM   = 3'b101;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_FETCH,
    DUMP_WAIT,
    DUMP_SEND
  } dump_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_ROM,
    RD_RAM,
    RD_BLOCK
  } rd_src_t;

  typedef struct packed {
    logic [8:0] rom_bank;
    logic [3:0] upper;
    logic       ram_en;
    logic       mode_sel;
  } mbc_regs_t;

  localparam mbc_regs_t REGS_RST = '{
    rom_bank: 9'd1,
    upper:    4'd0,
    ram_en:   1'b0,
    mode_sel: 1'b0
  };

endpackage

// File: rtl/mbc_dump_fsm.sv
// Battery-save dump engine: walks all cart RAM in address order
// and streams each byte out over a valid/ready port.
module mbc_dump_fsm
  import mbc_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clockgb,
  input  logic          resetn,
  input  logic          start,
  input  logic          ready,
  input  logic [7:0]    rdata,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic [7:0]    data,
  output logic          busy,
  output logic          started
);

  dump_state_t   state_q;
  dump_state_t   state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;

  // State, address counter and held byte
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_q <= DUMP_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next state: one RAM read, one latch, then hold for the consumer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    started = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          started = 1'b1;
          cnt_d   = '0;
          state_d = DUMP_FETCH;
        end
      end
      DUMP_FETCH: begin
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        data_d  = rdata;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (ready) begin
          if (cnt_q == '1) begin
            state_d = DUMP_IDLE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = DUMP_FETCH;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign addr  = cnt_q;
  assign data  = data_q;
  assign valid = (state_q == DUMP_SEND);
  assign busy  = (state_q != DUMP_IDLE);

endmodule

// File: rtl/mbc_gen.sv
// Parametrised MBC1/MBC5 cartridge bank controller with
// a cart RAM dump port for battery saves.
module mbc_gen
  import mbc_pkg::*;
#(
  parameter int MODE          = MODE_MBC1,
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2
) (
  input  logic                       clockgb,
  input  logic                       resetn,
  input  logic [15:0]                address,
  input  logic [7:0]                 indata,
  output logic [7:0]                 outdata,
  input  logic                       load,
  input  logic                       store,
  output logic [ROM_BANK_BITS+13:0]  rom_addr,
  input  logic [7:0]                 rom_data,
  output logic [RAM_BANK_BITS+12:0]  ram_addr,
  output logic [7:0]                 ram_wdata,
  output logic                       ram_we,
  input  logic [7:0]                 ram_rdata,
  input  logic                       dump_start,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [7:0]                 dump_data,
  output logic                       dump_busy,
  output logic                       ram_dirty
);

  localparam int ROM_AW = ROM_BANK_BITS + 14;
  localparam int RAM_AW = RAM_BANK_BITS + 13;

  mbc_regs_t         regs_q;
  mbc_regs_t         regs_d;
  rd_src_t           rd_q;
  rd_src_t           rd_d;
  logic [8:0]        rom_sel;
  logic [3:0]        ram_sel;
  logic [RAM_AW-1:0] dump_addr;
  logic              dump_started;
  logic              in_ram;

  assign in_ram = (address[15:13] == WIN_RAM);

  mbc_dump_fsm #(
    .AW(RAM_AW)
  ) u_dump (
    .clockgb (clockgb),
    .resetn  (resetn),
    .start   (dump_start),
    .ready   (dump_ready),
    .rdata   (ram_rdata),
    .addr    (dump_addr),
    .valid   (dump_valid),
    .data    (dump_data),
    .busy    (dump_busy),
    .started (dump_started)
  );

  // Banking registers
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      regs_q <= REGS_RST;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register writes decoded from the ROM window
  always_comb begin
    regs_d = regs_q;
    if (store && !address[15]) begin
      unique case (1'b1)
        address[15:13] == WIN_RAMEN: begin
          regs_d.ram_en = (indata[3:0] == RAM_KEY);
        end
        address[15:13] == WIN_ROMB: begin
          if (MODE == MODE_MBC5) begin
            if (address[12]) begin
              regs_d.rom_bank[8] = indata[0];
            end else begin
              regs_d.rom_bank[7:0] = indata;
            end
          end else begin
            regs_d.rom_bank[4:0] =
              (indata[4:0] == 5'd0) ? 5'd1 : indata[4:0];
          end
        end
        address[15:13] == WIN_UPPER: begin
          if (MODE == MODE_MBC5) begin
            regs_d.upper = indata[3:0];
          end else begin
            regs_d.upper = {2'b00, indata[1:0]};
          end
        end
        address[15:13] == WIN_MODE: begin
          if (MODE == MODE_MBC1) begin
            regs_d.mode_sel = indata[0];
          end
        end
        default: regs_d = regs_q;
      endcase
    end
  end

  // Effective ROM and RAM bank for the current address
  always_comb begin
    rom_sel = 9'd0;
    ram_sel = 4'd0;
    if (MODE == MODE_MBC5) begin
      if (address[15:14] == RGN_ROMX) begin
        rom_sel = regs_q.rom_bank;
      end
      ram_sel = regs_q.upper;
    end else begin
      if (address[15:14] == RGN_ROMX) begin
        rom_sel = {2'b00, regs_q.upper[1:0],
                   regs_q.rom_bank[4:0]};
      end else if (address[15:14] == RGN_ROM0
                   && regs_q.mode_sel) begin
        rom_sel = {2'b00, regs_q.upper[1:0], 5'd0};
      end
      if (regs_q.mode_sel) begin
        ram_sel = regs_q.upper;
      end
    end
  end

  assign rom_addr  = ROM_AW'({rom_sel, address[13:0]});
  assign ram_addr  = dump_busy ? dump_addr
                   : RAM_AW'({ram_sel, address[12:0]});
  assign ram_wdata = indata;
  assign ram_we    = store && in_ram && regs_q.ram_en
                   && !dump_busy;

  // Source of the read data returned next cycle
  always_comb begin
    rd_d = RD_NONE;
    if (load) begin
      if (!address[15]) begin
        rd_d = RD_ROM;
      end else if (in_ram) begin
        rd_d = (regs_q.ram_en && !dump_busy) ? RD_RAM
                                             : RD_BLOCK;
      end
    end
  end

  // Read source and dirty flag
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      rd_q      <= RD_NONE;
      ram_dirty <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (dump_started) begin
        ram_dirty <= 1'b0;
      end else if (ram_we) begin
        ram_dirty <= 1'b1;
      end
    end
  end

  // Bus read data; zero when not driving
  always_comb begin
    outdata = 8'h00;
    case (rd_q)
      RD_ROM:   outdata = rom_data;
      RD_RAM:   outdata = ram_rdata;
      RD_BLOCK: outdata = 8'hFF;
      default:  outdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mbc_gen.sv
// Bench for mbc_gen: an MBC1 and an MBC5 instance driven with random
// bus traffic, checked against a behavioural banking model.
module tb_mbc_gen;

  localparam int A_RB = 7;
  localparam int A_AB = 2;
  localparam int B_RB = 9;
  localparam int B_AB = 0;

  logic clockgb = 1'b0;
  logic resetn;
  always #5 clockgb = ~clockgb;

  logic [15:0] a_address, b_address;
  logic [7:0]  a_indata, b_indata, a_outdata, b_outdata;
  logic        a_load, a_store, b_load, b_store;
  logic [A_RB+13:0] a_rom_addr;
  logic [B_RB+13:0] b_rom_addr;
  logic [7:0]  a_rom_data, b_rom_data;
  logic [A_AB+12:0] a_ram_addr;
  logic [B_AB+12:0] b_ram_addr;
  logic [7:0]  a_ram_wdata, b_ram_wdata;
  logic        a_ram_we, b_ram_we;
  logic [7:0]  a_ram_rdata, b_ram_rdata;
  logic        a_dump_start, b_dump_start;
  logic        a_dump_valid, b_dump_valid;
  logic        a_dump_ready, b_dump_ready;
  logic [7:0]  a_dump_data, b_dump_data;
  logic        a_dump_busy, b_dump_busy;
  logic        a_ram_dirty, b_ram_dirty;

  mbc_gen #(.MODE(0), .ROM_BANK_BITS(A_RB), .RAM_BANK_BITS(A_AB)) u_a (
    .clockgb(clockgb), .resetn(resetn), .address(a_address),
    .indata(a_indata), .outdata(a_outdata), .load(a_load),
    .store(a_store), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
    .ram_rdata(a_ram_rdata), .dump_start(a_dump_start),
    .dump_valid(a_dump_valid), .dump_ready(a_dump_ready),
    .dump_data(a_dump_data), .dump_busy(a_dump_busy),
    .ram_dirty(a_ram_dirty)
  );

  mbc_gen #(.MODE(1), .ROM_BANK_BITS(B_RB), .RAM_BANK_BITS(B_AB)) u_b (
    .clockgb(clockgb), .resetn(resetn), .address(b_address),
    .indata(b_indata), .outdata(b_outdata), .load(b_load),
    .store(b_store), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
    .ram_rdata(b_ram_rdata), .dump_start(b_dump_start),
    .dump_valid(b_dump_valid), .dump_ready(b_dump_ready),
    .dump_data(b_dump_data), .dump_busy(b_dump_busy),
    .ram_dirty(b_ram_dirty)
  );

  function automatic logic [7:0] rom_fn(input logic [31:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ 8'h3C;
  endfunction

  // external memories
  logic [7:0] mem_a [32768];
  logic [7:0] mem_b [8192];
  logic [7:0] ref_a [32768];
  logic [7:0] ref_b [8192];
  logic       init_mem = 1'b0;

  always @(posedge clockgb) begin
    a_rom_data <= rom_fn(32'(a_rom_addr));
    b_rom_data <= rom_fn(32'(b_rom_addr));
    a_ram_rdata <= mem_a[a_ram_addr];
    b_ram_rdata <= mem_b[b_ram_addr];
    if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
    if (init_mem) begin
      for (int i = 0; i < 32768; i++) mem_a[i] <= ref_a[i];
      for (int i = 0; i < 8192; i++) mem_b[i] <= ref_b[i];
    end
  end

  // behavioural model of the bank registers
  int m_rom [2];
  int m_up [2];
  int m_en [2];
  int m_ms [2];
  int m_dirty [2];
  int exp_out [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rom[k] = 1; m_up[k] = 0; m_en[k] = 0; m_ms[k] = 0;
      m_dirty[k] = 0; exp_out[k] = 0;
    end
  endtask

  function automatic int exp_rom(input int k, input int ad);
    int bank;
    if (k == 0) begin
      if (ad < 'h4000) bank = (m_ms[0] != 0) ? m_up[0] * 32 : 0;
      else bank = m_up[0] * 32 + m_rom[0] % 32;
      return (bank * 16384 + ad % 16384) % (1 << (A_RB + 14));
    end
    bank = (ad < 'h4000) ? 0 : m_rom[1];
    return (bank * 16384 + ad % 16384) % (1 << (B_RB + 14));
  endfunction

  function automatic int exp_ram(input int k, input int ad);
    int bank;
    if (k == 0) begin
      bank = (m_ms[0] != 0) ? m_up[0] : 0;
      return (bank * 8192 + ad % 8192) % (1 << (A_AB + 13));
    end
    return (m_up[1] * 8192 + ad % 8192) % (1 << (B_AB + 13));
  endfunction

  task automatic model_store(input int k, input int ad, input int d);
    int v;
    if (ad < 'h2000) begin
      m_en[k] = ((d % 16) == 10) ? 1 : 0;
    end else if (k == 0) begin
      if (ad < 'h4000) begin
        v = d % 32;
        m_rom[0] = (v == 0) ? 1 : v;
      end else if (ad < 'h6000) m_up[0] = d % 4;
      else m_ms[0] = d % 2;
    end else begin
      if (ad < 'h3000) m_rom[1] = (m_rom[1] / 256) * 256 + d;
      else if (ad < 'h4000) m_rom[1] = (d % 2) * 256 + m_rom[1] % 256;
      else if (ad < 'h6000) m_up[1] = d % 16;
    end
  endtask

  // one bus cycle on instance k, checked against the model
  task automatic step(input int k, input bit ld, input bit st,
                      input int ad, input int d);
    int ea;
    int er;
    int nxt;
    bit rom_rg;
    bit ram_rg;
    bit we_exp;
    @(negedge clockgb);
    chk("a_outdata", 32'(a_outdata), 32'(exp_out[0]));
    chk("b_outdata", 32'(b_outdata), 32'(exp_out[1]));
    chk("a_dirty", 32'(a_ram_dirty), 32'(m_dirty[0]));
    chk("b_dirty", 32'(b_ram_dirty), 32'(m_dirty[1]));
    a_load = 0; a_store = 0; b_load = 0; b_store = 0;
    if (k == 0) begin
      a_load = ld; a_store = st;
      a_address = 16'(ad); a_indata = 8'(d);
    end else begin
      b_load = ld; b_store = st;
      b_address = 16'(ad); b_indata = 8'(d);
    end
    #1;
    rom_rg = (ad < 'h8000);
    ram_rg = (ad >= 'hA000) && (ad < 'hC000);
    nxt = 0;
    er = 0;
    we_exp = st && ram_rg && (m_en[k] != 0);
    if (ld && rom_rg) begin
      ea = exp_rom(k, ad);
      chk("rom_addr", (k == 0) ? 32'(a_rom_addr) : 32'(b_rom_addr),
          32'(ea));
      nxt = int'(rom_fn(32'(ea)));
    end
    if ((ld || st) && ram_rg) begin
      er = exp_ram(k, ad);
      chk("ram_addr", (k == 0) ? 32'(a_ram_addr) : 32'(b_ram_addr),
          32'(er));
      if (ld) begin
        if (m_en[k] == 0) nxt = 'hFF;
        else nxt = (k == 0) ? int'(ref_a[er]) : int'(ref_b[er]);
      end
    end
    chk("ram_we", (k == 0) ? 32'(a_ram_we) : 32'(b_ram_we),
        32'(we_exp));
    if (we_exp) begin
      if (k == 0) ref_a[er] = 8'(d);
      else ref_b[er] = 8'(d);
      m_dirty[k] = 1;
    end
    if (st && rom_rg) model_store(k, ad, d);
    exp_out[k] = nxt;
    exp_out[1-k] = 0;
  endtask

  // consume dump bytes from instance b with random backpressure
  task automatic dump_run(input int limit, output int got);
    int cyc;
    bit pend_ff;
    bit did_w;
    bit did_r;
    got = 0; cyc = 0; pend_ff = 0; did_w = 0; did_r = 0;
    while (got < limit && cyc < 60000) begin
      @(negedge clockgb);
      if (pend_ff) begin
        chk("d_rd_ff", 32'(b_outdata), 32'hFF);
        pend_ff = 0;
      end
      b_store = 0; b_load = 0;
      b_dump_ready = ($urandom % 2) == 1;
      if (got == 50 && !did_w) begin
        b_store = 1; b_address = 16'hA010; b_indata = 8'h77;
        #1 chk("d_we_drop", 32'(b_ram_we), 32'h0);
        did_w = 1;
      end else if (got == 60 && !did_r) begin
        b_load = 1; b_address = 16'hA000;
        pend_ff = 1; did_r = 1;
      end
      #1;
      if (b_dump_valid && b_dump_ready) begin
        chk("d_byte", 32'(b_dump_data), 32'(ref_b[got]));
        got++;
      end
      cyc++;
    end
    chk("d_count", 32'(got), 32'(limit));
  endtask

  task automatic pulse_dump();
    @(negedge clockgb);
    b_store = 0; b_load = 0; b_dump_ready = 0;
    b_dump_start = 1;
    @(negedge clockgb);
    b_dump_start = 0;
    #1;
    chk("d_busy_set", 32'(b_dump_busy), 32'h1);
    chk("d_dirty_clr", 32'(b_ram_dirty), 32'h0);
    m_dirty[1] = 0;
  endtask

  int ops;
  int k;
  int op;
  int ad;
  int d;
  int got;

  initial begin
    resetn = 0;
    a_address = 0; a_indata = 0; a_load = 0; a_store = 0;
    b_address = 0; b_indata = 0; b_load = 0; b_store = 0;
    a_dump_start = 0; a_dump_ready = 0;
    b_dump_start = 0; b_dump_ready = 0;
    for (int i = 0; i < 32768; i++) ref_a[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++) ref_b[i] = 8'($urandom);
    model_reset();
    init_mem = 1;
    repeat (3) @(posedge clockgb);
    @(negedge clockgb);
    init_mem = 0;
    #1;
    chk("rst_outdata", 32'(b_outdata), 32'h0);
    chk("rst_we", 32'(b_ram_we), 32'h0);
    chk("rst_valid", 32'(b_dump_valid), 32'h0);
    chk("rst_busy", 32'(b_dump_busy), 32'h0);
    chk("rst_dirty", 32'(b_ram_dirty), 32'h0);
    chk("rst_ddata", 32'(b_dump_data), 32'h0);
    chk("rst_a_out", 32'(a_outdata), 32'h0);
    resetn = 1;

    // MBC1 bank zero remap and upper bits
    step(0, 0, 1, 'h2000, 'h00);
    step(0, 1, 0, 'h4000, 0);
    chk("p1_bank1", 32'(a_rom_addr), 32'h4000);
    step(0, 0, 1, 'h2000, 'h20);
    step(0, 0, 1, 'h4000, 'h01);
    step(0, 1, 0, 'h4000, 0);
    chk("p1_bank21", 32'(a_rom_addr), 32'h84000);
    step(0, 0, 1, 'h6000, 'h01);
    step(0, 0, 1, 'h4000, 'h02);
    step(0, 1, 0, 'h0123, 0);
    chk("p2_rom0", 32'(a_rom_addr), 32'h100123);
    step(0, 0, 1, 'h0000, 'h0A);
    step(0, 1, 0, 'hA005, 0);
    chk("p2_ram", 32'(a_ram_addr), 32'h4005);

    // MBC5 9-bit bank and read timing
    step(1, 0, 1, 'h2000, 'h00);
    step(1, 0, 1, 'h3000, 'h01);
    step(1, 1, 0, 'h7FFF, 0);
    chk("p3_rom", 32'(b_rom_addr), 32'h403FFF);
    step(1, 0, 0, 0, 0);
    chk("p3_out", 32'(b_outdata), 32'(rom_fn(32'h403FFF)));
    step(1, 0, 0, 0, 0);
    chk("p3_zero", 32'(b_outdata), 32'h0);

    // RAM gating
    step(1, 0, 1, 'hA000, 'h55);
    chk("p4_we0", 32'(b_ram_we), 32'h0);
    step(1, 1, 0, 'hA000, 0);
    chk("p4_dirty0", 32'(b_ram_dirty), 32'h0);
    step(1, 0, 0, 0, 0);
    chk("p4_ff", 32'(b_outdata), 32'hFF);
    step(1, 0, 1, 'h0000, 'h0A);
    step(1, 0, 1, 'hA000, 'h55);
    chk("p4_we1", 32'(b_ram_we), 32'h1);
    step(1, 0, 0, 0, 0);
    chk("p4_dirty1", 32'(b_ram_dirty), 32'h1);

    // random bus traffic on both instances
    for (ops = 0; ops < 600; ops++) begin
      k = $urandom % 2;
      op = $urandom % 6;
      d = $urandom % 256;
      case (op)
        0: begin
          ad = $urandom % 'h8000;
          if (ad < 'h2000 && ($urandom % 2) == 1) d = 'h0A;
          step(k, 0, 1, ad, d);
        end
        1: step(k, 1, 0, $urandom % 'h8000, 0);
        2: step(k, 0, 1, 'hA000 + $urandom % 'h2000, d);
        3: step(k, 1, 0, 'hA000 + $urandom % 'h2000, 0);
        4: step(k, 1, 0, 'hC000 + $urandom % 'h4000, 0);
        default: step(k, 0, 0, 0, 0);
      endcase
    end

    // full dump of instance b
    step(1, 0, 1, 'h0000, 'h0A);
    step(1, 0, 1, 'hA123, 'h99);
    step(1, 0, 0, 0, 0);
    chk("d_dirty_pre", 32'(b_ram_dirty), 32'h1);
    pulse_dump();
    dump_run(8192, got);
    @(negedge clockgb);
    b_dump_ready = 0; b_store = 0; b_load = 0;
    #1;
    chk("d_busy_end", 32'(b_dump_busy), 32'h0);
    chk("d_valid_end", 32'(b_dump_valid), 32'h0);
    chk("d_dirty_end", 32'(b_ram_dirty), 32'h0);

    // reset in the middle of a dump
    pulse_dump();
    dump_run(100, got);
    resetn = 0;
    #1;
    chk("r_busy", 32'(b_dump_busy), 32'h0);
    chk("r_valid", 32'(b_dump_valid), 32'h0);
    model_reset();
    @(negedge clockgb);
    b_dump_ready = 0; b_store = 0; b_load = 0;
    resetn = 1;
    step(1, 1, 0, 'h4000, 0);
    chk("r_bank1", 32'(b_rom_addr), 32'h4000);
    step(1, 0, 0, 0, 0);
    pulse_dump();
    dump_run(5, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
